// File: rtl/retire_buffer_if.sv
// Issue / writeback / commit bundle between the retire buffer and its neighbours.
interface retire_buffer_if #(
    parameter int unsigned NR_ENTRIES      = 8,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DATA_W          = 64
);
    localparam int unsigned TAG_W = $clog2(NR_ENTRIES);
    localparam int unsigned CNT_W = TAG_W + 1;

    logic                                    flush_i;
    logic                                    issue_valid_i;
    logic                                    issue_ready_o;
    logic [DATA_W-1:0]                       issue_data_i;
    logic [TAG_W-1:0]                        issue_tag_o;
    logic                                    wb_valid_i;
    logic [TAG_W-1:0]                        wb_tag_i;
    logic [DATA_W-1:0]                       wb_result_i;
    logic [NR_COMMIT_PORTS-1:0]              commit_valid_o;
    logic [NR_COMMIT_PORTS-1:0][DATA_W-1:0]  commit_data_o;
    logic [NR_COMMIT_PORTS-1:0]              commit_ack_i;
    logic [CNT_W-1:0]                        count_o;

    // Issue/writeback/commit driver side.
    modport master (
        output flush_i, issue_valid_i, issue_data_i,
               wb_valid_i, wb_tag_i, wb_result_i, commit_ack_i,
        input  issue_ready_o, issue_tag_o, commit_valid_o, commit_data_o, count_o
    );

    // Retire buffer side.
    modport slave (
        input  flush_i, issue_valid_i, issue_data_i,
               wb_valid_i, wb_tag_i, wb_result_i, commit_ack_i,
        output issue_ready_o, issue_tag_o, commit_valid_o, commit_data_o, count_o
    );
endinterface

// File: rtl/retire_buffer.sv
// In-order retirement buffer: tags issued instructions, marks them done on
// writeback and offers the oldest completed run to up to NR_COMMIT_PORTS ports.
module retire_buffer #(
    parameter int unsigned NR_ENTRIES      = 8,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DATA_W          = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    retire_buffer_if.slave bus
);
    localparam int unsigned TAG_W = $clog2(NR_ENTRIES);
    localparam int unsigned CNT_W = TAG_W + 1;

    logic [NR_ENTRIES-1:0]      r_occupied;
    logic [NR_ENTRIES-1:0]      r_done;
    logic [DATA_W-1:0]          r_data [NR_ENTRIES];
    logic [TAG_W-1:0]           r_head;
    logic [TAG_W-1:0]           r_tail;
    logic [CNT_W-1:0]           r_count;

    logic                       w_issue_ready;
    logic                       w_issue_fire;
    logic                       w_wb_fire;
    logic [TAG_W-1:0]           w_port_idx [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0] w_commit_valid;
    logic [NR_COMMIT_PORTS-1:0] w_ret_port;
    logic [CNT_W-1:0]           w_ret_n;
    logic [NR_ENTRIES-1:0]      w_occupied_nxt;
    logic [NR_ENTRIES-1:0]      w_done_nxt;

    // Handshake qualifiers; ready looks only at the registered count.
    always_comb begin
        w_issue_ready = (r_count != CNT_W'(NR_ENTRIES));
        w_issue_fire  = bus.issue_valid_i && w_issue_ready && !bus.flush_i;
        w_wb_fire     = bus.wb_valid_i && r_occupied[bus.wb_tag_i] && !bus.flush_i;
    end

    // Commit window: entry index per port and the in-order done chain.
    always_comb begin
        logic chain;
        chain = 1'b1;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            w_port_idx[k]     = r_head + TAG_W'(k);
            chain             = chain & r_occupied[w_port_idx[k]] & r_done[w_port_idx[k]];
            w_commit_valid[k] = chain;
        end
    end

    // Retire count: leading run of ports that are both valid and acked.
    always_comb begin
        logic chain;
        chain   = 1'b1;
        w_ret_n = '0;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            chain         = chain & w_commit_valid[k] & bus.commit_ack_i[k];
            w_ret_port[k] = chain;
            w_ret_n       = w_ret_n + CNT_W'(chain);
        end
    end

    // Next entry flags: writeback, then retire clears, then issue allocation.
    always_comb begin
        w_occupied_nxt = r_occupied;
        w_done_nxt     = r_done;
        if (w_wb_fire) begin
            w_done_nxt[bus.wb_tag_i] = 1'b1;
        end
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            if (w_ret_port[k]) begin
                w_occupied_nxt[w_port_idx[k]] = 1'b0;
                w_done_nxt[w_port_idx[k]]     = 1'b0;
            end
        end
        if (w_issue_fire) begin
            w_occupied_nxt[r_tail] = 1'b1;
            w_done_nxt[r_tail]     = 1'b0;
        end
        if (bus.flush_i) begin
            w_occupied_nxt = '0;
            w_done_nxt     = '0;
        end
    end

    // Control state; flush returns to the reset state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_occupied <= '0;
            r_done     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (bus.flush_i) begin
            r_occupied <= '0;
            r_done     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_occupied <= w_occupied_nxt;
            r_done     <= w_done_nxt;
            r_head     <= r_head + w_ret_n[TAG_W-1:0];
            r_tail     <= r_tail + TAG_W'(w_issue_fire);
            r_count    <= r_count + CNT_W'(w_issue_fire) - w_ret_n;
        end
    end

    // Payload RAM, not reset; issue and writeback never hit the same entry.
    always_ff @(posedge clk_i) begin
        if (w_issue_fire) begin
            r_data[r_tail] <= bus.issue_data_i;
        end
        if (w_wb_fire) begin
            r_data[bus.wb_tag_i] <= bus.wb_result_i;
        end
    end

    // Output mapping.
    always_comb begin
        bus.issue_ready_o  = w_issue_ready;
        bus.issue_tag_o    = r_tail;
        bus.count_o        = r_count;
        bus.commit_valid_o = w_commit_valid;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            bus.commit_data_o[k] = r_data[w_port_idx[k]];
        end
    end
endmodule

// File: tb/tb_retire_buffer.sv
// Self-checking bench for retire_buffer: directed scenarios then random traffic,
// compared every cycle against an in-order queue model.
module tb_retire_buffer;
    localparam int N = 8;
    localparam int P = 2;
    localparam int W = 64;

    typedef struct {
        int          tag;
        logic [63:0] data;
        bit          done;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    ent_t q[$];
    int   m_tail = 0;

    retire_buffer_if #(.NR_ENTRIES(N), .NR_COMMIT_PORTS(P), .DATA_W(W)) bus ();

    retire_buffer #(.NR_ENTRIES(N), .NR_COMMIT_PORTS(P), .DATA_W(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.flush_i       = 1'b0;
        bus.issue_valid_i = 1'b0;
        bus.issue_data_i  = '0;
        bus.wb_valid_i    = 1'b0;
        bus.wb_tag_i      = '0;
        bus.wb_result_i   = '0;
        bus.commit_ack_i  = '0;
    endtask

    // Expected outputs derived from the queue of live entries, oldest first.
    task automatic check_outputs();
        bit v;
        chk("ready", 64'(bus.issue_ready_o), 64'(q.size() < N));
        chk("tag",   64'(bus.issue_tag_o),   64'(m_tail));
        chk("count", 64'(bus.count_o),       64'(q.size()));
        v = 1'b1;
        for (int k = 0; k < P; k++) begin
            v = v && (k < q.size()) && q[k].done;
            chk($sformatf("valid%0d", k), 64'(bus.commit_valid_o[k]), 64'(v));
            if (v) chk($sformatf("data%0d", k), bus.commit_data_o[k], q[k].data);
        end
    endtask

    // One clock of the reference model, using the inputs held over the edge.
    task automatic model_update();
        int n;
        bit ifire;
        if (bus.flush_i) begin
            q.delete();
            m_tail = 0;
            return;
        end
        n = 0;
        for (int k = 0; k < P; k++)
            if (n == k && k < q.size() && q[k].done && bus.commit_ack_i[k]) n++;
        ifire = bus.issue_valid_i && (q.size() < N);
        if (bus.wb_valid_i)
            foreach (q[i])
                if (q[i].tag == int'(bus.wb_tag_i)) begin
                    q[i].done = 1'b1;
                    q[i].data = bus.wb_result_i;
                end
        for (int i = 0; i < n; i++) void'(q.pop_front());
        if (ifire) begin
            q.push_back('{tag: m_tail, data: bus.issue_data_i, done: 1'b0});
            m_tail = (m_tail + 1) % N;
        end
    endtask

    task automatic step();
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
        idle();
    endtask

    task automatic do_issue(input logic [63:0] d);
        bus.issue_valid_i = 1'b1;
        bus.issue_data_i  = d;
        step();
    endtask

    task automatic do_wb(input int t, input logic [63:0] d);
        bus.wb_valid_i  = 1'b1;
        bus.wb_tag_i    = 3'(t);
        bus.wb_result_i = d;
        step();
    endtask

    task automatic do_ack(input logic [1:0] a);
        bus.commit_ack_i = a;
        step();
    endtask

    task automatic do_flush();
        bus.flush_i = 1'b1;
        step();
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        // Reset state.
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_ready", 64'(bus.issue_ready_o), 64'd1);
        chk("rst_valid", 64'(bus.commit_valid_o), 64'd0);
        chk("rst_tag",   64'(bus.issue_tag_o), 64'd0);
        rst = 1'b0;
        step();

        // Out-of-order writeback, in-order commit.
        for (int i = 0; i < 3; i++) begin
            chk("plan_tag", 64'(bus.issue_tag_o), 64'(i));
            do_issue(64'hA0 + 64'(i));
        end
        do_wb(1, 64'h11);
        chk("plan_wait", 64'(bus.commit_valid_o), 64'd0);
        do_wb(0, 64'h10);
        chk("plan_v11", 64'(bus.commit_valid_o), 64'd3);
        chk("plan_d0",  bus.commit_data_o[0], 64'h10);
        chk("plan_d1",  bus.commit_data_o[1], 64'h11);
        do_ack(2'b11);
        chk("plan_cnt1", 64'(bus.count_o), 64'd1);
        chk("plan_head", 64'(bus.issue_tag_o - 3'(bus.count_o)), 64'd2);
        do_flush();

        // Fill, drop when full, retire one, tag wraps to 0.
        for (int i = 0; i < N; i++) do_issue({$urandom, $urandom});
        chk("full_cnt",   64'(bus.count_o), 64'd8);
        chk("full_ready", 64'(bus.issue_ready_o), 64'd0);
        do_issue(64'hDEAD);
        chk("drop_cnt", 64'(bus.count_o), 64'd8);
        do_wb(0, 64'h55);
        do_ack(2'b01);
        chk("rel_ready", 64'(bus.issue_ready_o), 64'd1);
        chk("rel_tag",   64'(bus.issue_tag_o), 64'd0);
        do_issue(64'h77);
        do_flush();

        // Wrap-around: move head to 6, then tags 6,7,0,1.
        for (int i = 0; i < 6; i++) do_issue(64'(i));
        for (int i = 0; i < 6; i++) do_wb(i, 64'(i));
        repeat (3) do_ack(2'b11);
        chk("wrap_tag", 64'(bus.issue_tag_o), 64'd6);
        for (int i = 0; i < 4; i++) do_issue(64'hF0);
        for (int i = 0; i < 4; i++) do_wb((6 + i) % N, 64'h100 + 64'((6 + i) % N));
        chk("wrap_d0", bus.commit_data_o[0], 64'h106);
        chk("wrap_d1", bus.commit_data_o[1], 64'h107);
        do_ack(2'b11);
        chk("wrap_d2", bus.commit_data_o[0], 64'h100);
        chk("wrap_d3", bus.commit_data_o[1], 64'h101);
        do_ack(2'b11);
        chk("wrap_cnt", 64'(bus.count_o), 64'd0);
        do_flush();

        // Ack above a zero is ignored.
        do_issue(64'h1);
        do_issue(64'h2);
        do_wb(0, 64'h21);
        do_wb(1, 64'h22);
        do_ack(2'b10);
        chk("gap_cnt", 64'(bus.count_o), 64'd2);
        do_ack(2'b11);
        chk("gap_cnt0", 64'(bus.count_o), 64'd0);

        // Flush beats same-cycle issue, writeback and ack.
        do_flush();
        for (int i = 0; i < 5; i++) do_issue(64'(i));
        do_wb(0, 64'h9);
        bus.issue_valid_i = 1'b1;
        bus.issue_data_i  = 64'h33;
        bus.wb_valid_i    = 1'b1;
        bus.wb_tag_i      = 3'd1;
        bus.commit_ack_i  = 2'b01;
        do_flush();
        chk("fl_cnt",   64'(bus.count_o), 64'd0);
        chk("fl_valid", 64'(bus.commit_valid_o), 64'd0);
        chk("fl_tag",   64'(bus.issue_tag_o), 64'd0);
        do_issue(64'h44);
        chk("fl_cnt1", 64'(bus.count_o), 64'd1);

        // Asynchronous reset in mid-operation.
        do_issue(64'h45);
        rst = 1'b1;
        #2;
        chk("arst_cnt", 64'(bus.count_o), 64'd0);
        chk("arst_tag", 64'(bus.issue_tag_o), 64'd0);
        q.delete();
        m_tail = 0;
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.issue_valid_i = ($urandom_range(0, 3) != 0);
            bus.issue_data_i  = {$urandom, $urandom};
            bus.wb_valid_i    = ($urandom_range(0, 2) != 0);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                bus.wb_tag_i = 3'(q[$urandom_range(0, q.size() - 1)].tag);
            else
                bus.wb_tag_i = 3'($urandom_range(0, N - 1));
            bus.wb_result_i  = {$urandom, $urandom};
            bus.commit_ack_i = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'($urandom);
            bus.flush_i      = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
